// File: rtl/serial_parity_checker.sv
// Receive side of the XOR-parity serial link: deserialises one framed word
// (start, DATA_W data bits LSB first, parity, stop) and flags parity/framing errors.
module serial_parity_checker #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BIT_VALID,
  input  logic              IN_BIT,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_VALID,
  output logic              PARITY_ERR,
  output logic              FRAME_ERR,
  output logic              BUSY,
  output logic [1:0]        DBG_STATE
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Handshake: a line bit is consumed on every rising edge where BIT_VALID=1;
  // there is no back-pressure. DATA_VALID is a one-cycle pulse with no ready.
  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                acc_q;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   shift_d;
  logic [DATA_W-1:0]   data_out_q;
  logic                data_valid_q;
  logic                parity_err_q;
  logic                frame_err_q;
  logic                busy_q;

  // New bit enters at the MSB so the first (LSB) bit ends up at bit 0.
  generate
    if (DATA_W == 1) begin : g_shift_1
      assign shift_d = IN_BIT;
    end else begin : g_shift_n
      assign shift_d = {IN_BIT, shift_q[DATA_W-1:1]};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (BIT_VALID) begin
        case (state_q)
          IDLE: begin
            if (!IN_BIT) begin
              state_q <= DATA;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              acc_q   <= 1'b0;
            end
          end
          DATA: begin
            shift_q <= shift_d;
            acc_q   <= acc_q ^ IN_BIT;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) state_q <= PARITY;
          end
          PARITY: begin
            acc_q   <= acc_q ^ IN_BIT;
            state_q <= STOP;
          end
          STOP: begin
            // A 0 stop bit is reported, never reused as the next start bit.
            data_out_q   <= shift_q;
            data_valid_q <= 1'b1;
            parity_err_q <= (acc_q != PARITY_ODD);
            frame_err_q  <= ~IN_BIT;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign DATA_OUT   = data_out_q;
  assign DATA_VALID = data_valid_q;
  assign PARITY_ERR = parity_err_q;
  assign FRAME_ERR  = frame_err_q;
  assign BUSY       = busy_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: even and odd parity instances share one line;
// expected results come from frame-level arithmetic on the bits sent.
module tb_serial_parity_checker;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BIT_VALID = 1'b0;
  logic       IN_BIT = 1'b1;
  logic [7:0] data_e, data_o;
  logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;
  logic [1:0] st_e, st_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  serial_parity_checker #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_even (
    .CLK(CLK), .RST(RST), .BIT_VALID(BIT_VALID), .IN_BIT(IN_BIT),
    .DATA_OUT(data_e), .DATA_VALID(dv_e), .PARITY_ERR(pe_e), .FRAME_ERR(fe_e),
    .BUSY(busy_e), .DBG_STATE(st_e)
  );

  serial_parity_checker #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
    .CLK(CLK), .RST(RST), .BIT_VALID(BIT_VALID), .IN_BIT(IN_BIT),
    .DATA_OUT(data_o), .DATA_VALID(dv_o), .PARITY_ERR(pe_o), .FRAME_ERR(fe_o),
    .BUSY(busy_o), .DBG_STATE(st_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit b, input int gap);
    BIT_VALID = 1'b1;
    IN_BIT = b;
    tick();
    repeat (gap) begin
      BIT_VALID = 1'b0;
      IN_BIT = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic idle(input int n, input logic [7:0] last);
    repeat (n) begin
      BIT_VALID = 1'b1;
      IN_BIT = 1'b1;
      tick();
      check("idle_dv", {dv_e, dv_o}, 2'b00);
      check("idle_busy", {busy_e, busy_o}, 2'b00);
      check("idle_hold", {data_e, data_o}, {last, last});
    end
  endtask

  // Frame-level model: parity error when XOR of data and parity bit differs
  // from the configured parity; framing error when the stop bit is 0.
  task automatic send_frame(input logic [7:0] d, input bit p, input bit stop, input int gap);
    bit x;
    x = (^d) ^ p;
    drive(1'b0, gap);
    check("start_busy", {busy_e, busy_o}, 2'b11);
    for (int i = 0; i < 8; i++) begin
      drive(d[i], gap);
      check("data_dv_low", {dv_e, dv_o}, 2'b00);
    end
    drive(p, gap);
    check("par_dv_low", {dv_e, dv_o}, 2'b00);
    BIT_VALID = 1'b1;
    IN_BIT = stop;
    tick();
    check("dv", {dv_e, dv_o}, 2'b11);
    check("data_even", data_e, d);
    check("data_odd", data_o, d);
    check("perr_even", pe_e, x);
    check("perr_odd", pe_o, !x);
    check("ferr", {fe_e, fe_o}, {!stop, !stop});
    check("stop_busy", {busy_e, busy_o}, 2'b00);
  endtask

  initial begin
    int t0;
    logic [7:0] d;
    int gap;
    int n_idle;
    bit p;
    bit stop;

    // Reset with random line activity
    RST = 1'b1;
    repeat (3) begin
      BIT_VALID = 1'($urandom_range(0, 1));
      IN_BIT = 1'($urandom_range(0, 1));
      tick();
      check("rst_data", {data_e, data_o}, 16'h0);
      check("rst_flags", {dv_e, pe_e, fe_e, dv_o, pe_o, fe_o}, 6'h0);
      check("rst_busy", {busy_e, busy_o}, 2'b00);
    end
    RST = 1'b0;
    idle(5, 8'h00);

    // Good frame 0xA5, even parity bit 0
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    idle(1, 8'hA5);

    // Parity cases on 0x07
    send_frame(8'h07, 1'b0, 1'b1, 0);
    idle(1, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 0);
    idle(1, 8'h07);

    // Framing error with 2-cycle stalls; a following 1 must not start a frame
    send_frame(8'hA5, 1'b0, 1'b0, 2);
    idle(2, 8'hA5);

    // Reset after the 4th data bit discards the partial frame
    drive(1'b0, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 0);
    RST = 1'b1;
    BIT_VALID = 1'b1;
    IN_BIT = 1'b0;
    tick();
    RST = 1'b0;
    check("midrst_dv", {dv_e, dv_o}, 2'b00);
    check("midrst_busy", {busy_e, busy_o}, 2'b00);
    idle(2, 8'h00);

    // Back-to-back frames, no idle gap
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    t0 = cyc;
    send_frame(8'hC3, 1'b0, 1'b1, 0);
    check("b2b_spacing", 32'(cyc - t0), 32'd11);
    idle(1, 8'hC3);

    // Random frames against the frame-level model
    d = 8'hC3;
    for (int k = 0; k < 20; k++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 2);
      n_idle = $urandom_range(0, 3);
      send_frame(d, p, stop, gap);
      idle(n_idle, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
